// File: rtl/flag_pkg.sv
`default_nettype none
// ============================================================================
// Package     : flag_pkg
// Description : Shared constants, pop FSM state type and a one-hot helper
//               for the flag_ack8_reg sticky event-flag register.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package flag_pkg;

  localparam int FLAG_W     = 8;
  localparam int FLAG_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_EMPTY = 2'd2
  } pop_state_t;

  // Expand a channel index into a single-bit mask.
  function automatic logic [FLAG_W-1:0] idx_to_onehot(input logic [FLAG_IDX_W-1:0] idx);
    return FLAG_W'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flag_ack8_reg_if.sv
`default_nettype none
// ============================================================================
// Interface   : flag_ack8_reg_if
// Description : Consumer-side handshakes of the flag register: the
//               write-1-to-clear port and the pop request/response port.
// Signals     : clr_valid, clr_bits, clr_ready   - clear handshake
//               pop_req, pop_valid, pop_empty,
//               pop_idx                          - pop handshake
// Modports    : master - consumer side, slave - flag register side
// Revision    : 1.0 - initial release
// ============================================================================
interface flag_ack8_reg_if;

  logic                             clr_valid;
  logic [flag_pkg::FLAG_W-1:0]      clr_bits;
  logic                             clr_ready;
  logic                             pop_req;
  logic                             pop_valid;
  logic                             pop_empty;
  logic [flag_pkg::FLAG_IDX_W-1:0]  pop_idx;

  modport master (
    output clr_valid, clr_bits, pop_req,
    input  clr_ready, pop_valid, pop_empty, pop_idx
  );

  modport slave (
    input  clr_valid, clr_bits, pop_req,
    output clr_ready, pop_valid, pop_empty, pop_idx
  );

endinterface
`default_nettype wire

// File: rtl/or8_gate.sv
`default_nettype none
// ============================================================================
// Module      : or8_gate
// Description : 8-bit bitwise OR of two event masks.
// Ports       : a, b - input masks
//               y    - a | b
// Revision    : 1.0 - initial release
// ============================================================================
module or8_gate (
  input  wire logic [7:0] a,
  input  wire logic [7:0] b,
  output logic      [7:0] y
);

  assign y = a | b;

endmodule
`default_nettype wire

// File: rtl/prio_enc8.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc8
// Description : Combinational lowest-set-bit priority encoder, 8 inputs.
//               Bit 0 has the highest priority.
// Ports       : req - request vector
//               idx - index of lowest set bit (0 when none set)
//               any - at least one request bit set
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc8 (
  input  wire logic [7:0] req,
  output logic      [2:0] idx,
  output logic            any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = 3'd0;
    any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/flag_ack8_reg.sv
`default_nettype none
// ============================================================================
// Module      : flag_ack8_reg
// Description : 8-channel sticky event-flag register. Event pulses OR into
//               sticky flags; flags are retired by a write-1-to-clear port
//               or by a pop that returns and clears the lowest pending
//               enabled flag. Produces a registered interrupt and
//               per-channel overflow flags.
// Ports       : clk       - clock, rising edge
//               rst_n     - asynchronous active-low reset
//               evt_in    - event pulses, one bit per channel
//               en_mask   - interrupt/pop enable per channel
//               flags_out - sticky flag register
//               ovf_out   - event seen while flag already set
//               irq       - registered OR of enabled pending flags
//               bus       - clear and pop handshakes (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module flag_ack8_reg
  import flag_pkg::*;
#(
  parameter int WIDTH = FLAG_W,
  parameter int IDX_W = FLAG_IDX_W
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] evt_in,
  input  wire logic [WIDTH-1:0] en_mask,
  output logic      [WIDTH-1:0] flags_out,
  output logic      [WIDTH-1:0] ovf_out,
  output logic                  irq,
  flag_ack8_reg_if.slave        bus
);

  pop_state_t       state;
  logic [WIDTH-1:0] flags;
  logic [WIDTH-1:0] ovf;
  logic             pop_valid_r;
  logic             pop_empty_r;
  logic [IDX_W-1:0] pop_idx_r;

  logic [WIDTH-1:0] pending;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             clr_ready;
  logic [WIDTH-1:0] clr_eff;
  logic [WIDTH-1:0] pop_clr;
  logic [WIDTH-1:0] clear_all;
  logic [WIDTH-1:0] kept;
  logic [WIDTH-1:0] flags_next;

  assign pending = flags & en_mask;

  prio_enc8 u_enc (
    .req (pending),
    .idx (enc_idx),
    .any (enc_any)
  );

  // The clear port is stalled only while a pop is retiring its bit, so the
  // two clear paths never need arbitration beyond a plain OR.
  assign clr_ready = (state != ST_SERVE);
  assign clr_eff   = (bus.clr_valid && clr_ready) ? bus.clr_bits : '0;
  // pop_idx_r holds the index captured in IDLE for the whole SERVE cycle.
  assign pop_clr   = (state == ST_SERVE) ? idx_to_onehot(pop_idx_r) : '0;
  assign clear_all = clr_eff | pop_clr;
  assign kept      = flags & ~clear_all;

  // Events are OR-ed in after clearing, so a coincident set always wins.
  or8_gate u_merge (
    .a (kept),
    .b (evt_in),
    .y (flags_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
      ovf   <= '0;
      irq   <= 1'b0;
    end else begin
      flags <= flags_next;
      // An event landing on a bit being cleared is a fresh set, not a loss.
      ovf   <= (ovf & ~clear_all) | (evt_in & flags & ~clear_all);
      irq   <= |pending;
    end
  end

  // Pop FSM: a response is one registered strobe cycle, then back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pop_valid_r <= 1'b0;
      pop_empty_r <= 1'b0;
      pop_idx_r   <= '0;
    end else begin
      pop_valid_r <= 1'b0;
      pop_empty_r <= 1'b0;
      pop_idx_r   <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.pop_req) begin
            pop_valid_r <= 1'b1;
            if (enc_any) begin
              state     <= ST_SERVE;
              pop_idx_r <= enc_idx;
            end else begin
              state       <= ST_EMPTY;
              pop_empty_r <= 1'b1;
            end
          end
        end
        ST_SERVE: state <= ST_IDLE;
        ST_EMPTY: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign flags_out     = flags;
  assign ovf_out       = ovf;
  assign bus.clr_ready = clr_ready;
  assign bus.pop_valid = pop_valid_r;
  assign bus.pop_empty = pop_empty_r;
  assign bus.pop_idx   = pop_idx_r;

endmodule
`default_nettype wire

// File: doc/flag_ack8_reg.md
Name: flag_ack8_reg

Overview:
- 8-channel sticky event-flag register: the receiving and acknowledging end for the bitwise OR-accumulated event masks the gate library produces.
- Event pulses are OR-merged into sticky flags.
- A consumer retires flags through one of two paths:
  - a write-1-to-clear handshake port;
  - a "pop" handshake that returns and clears the lowest-index pending enabled flag.
- Also produces a registered interrupt and per-channel overflow indication.

Parameters:
- WIDTH, 8, number of flag channels (only 8 is verified).
- IDX_W, 3, width of the pop index (clog2 of WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- evt_in  input  WIDTH  event pulses; bit high for a cycle sets the flag.
- en_mask  input  WIDTH  interrupt/pop enable per channel.
- clr_valid  input  1  clear request valid.
- clr_bits  input  WIDTH  write-1-to-clear mask; sampled when clr_valid && clr_ready.
- clr_ready  output  1  clear port can accept.
- pop_req  input  1  request to pop the lowest pending enabled flag.
- pop_valid  output  1  one-cycle pop response strobe.
- pop_empty  output  1  qualifies pop_valid: no enabled flag was pending.
- pop_idx  output  IDX_W  index of popped flag; 0 when pop_empty.
- flags_out  output  WIDTH  current sticky flags (register value).
- ovf_out  output  WIDTH  per-channel overflow: event arrived while flag already set.
- irq  output  1  registered OR of (flags & en_mask).

Behaviour:
- Reset (async, rst_n low): flags, ovf, irq, pop_valid, pop_empty, pop_idx = 0; FSM = IDLE; clr_ready = 1 after reset release. Reset mid-pop aborts the pop with no response.
- Flag update each cycle:
  - flags_next = (flags & ~clr_eff & ~pop_clr) | evt_in.
  - clr_eff = clr_bits when clr_valid && clr_ready, else 0.
  - pop_clr = one-hot of the captured index during SERVE, else 0.
- Simultaneous set and clear on the same bit: set wins, so the event is never lost.
- Overflow:
  - ovf_next[i] = (ovf[i] & ~clear_i) | (evt_in[i] & flags[i] & ~clear_i), where clear_i is the bit i clear from either path.
  - An event coincident with a clear sets the flag but not ovf.
- irq = registered |(flags & en_mask), so it lags flags by one cycle. en_mask changes take effect on irq one cycle later.
- Pop FSM states: IDLE, SERVE, EMPTY.
  - IDLE: clr_ready = 1.
    - If pop_req and (flags & en_mask) != 0: capture the lowest set index of (flags & en_mask); go to SERVE.
    - If pop_req with no enabled flags pending: go to EMPTY.
    - Otherwise stay in IDLE.
  - SERVE: pop_valid = 1, pop_empty = 0, pop_idx = captured index; clr_ready = 0; the captured bit clears at the end of this cycle. Always return to IDLE.
  - EMPTY: pop_valid = 1, pop_empty = 1, pop_idx = 0; clr_ready = 1. Always return to IDLE.
- Pop latency: 1 cycle from pop_req sampled to the pop_valid strobe.
- pop_req held high yields one response every 2 cycles.
- Index is captured in IDLE. A clear-port clear of that bit in the same IDLE cycle still pops that index; the clear is harmless.
- pop_valid, pop_empty and pop_idx are registered outputs and low/zero outside a response cycle.
- clr_valid held while clr_ready = 0 stays pending; the master keeps clr_bits stable until accepted.
- Width rule: pop_idx is a zero-extended WIDTH-to-IDX_W priority encode, LSB has highest priority.

Decomposition:
- Shared package (flag_pkg) holds:
  - FLAG_W = 8;
  - FLAG_IDX_W = 3;
  - pop FSM state enum {ST_IDLE, ST_SERVE, ST_EMPTY}.
- One sub-module is natural: prio_enc8, a combinational lowest-set-bit encoder returning index plus any-valid.
- Flag merging reuses the library's or8_gate for the (cleared-flags | evt_in) term.

Test Plan:
- Reset with evt_in = 0xFF asserted during reset -> flags_out = 0x00, irq = 0, clr_ready = 1, pop_valid = 0. Release -> flags_out = 0xFF next cycle.
- evt_in = 0x24 pulse, en_mask = 0xFF -> flags_out = 0x24 next cycle, irq = 1 one cycle later. pop_req -> pop_valid with pop_idx = 2, flags = 0x20. Second pop -> idx 5, flags = 0x00, irq falls next cycle.
- flags = 0x01, evt_in[0] = 1 again -> ovf_out = 0x01. Clear with clr_bits = 0x01 -> flags and ovf both 0x00.
- Same cycle: clr_valid with clr_bits = 0x08 and evt_in = 0x08 -> flags[3] stays 1, ovf[3] stays 0.
- en_mask = 0x00, flags = 0x10, pop_req -> pop_valid = 1, pop_empty = 1, pop_idx = 0. flags unchanged, irq = 0.
- pop_req with flags = 0x80, and clr_valid asserted during SERVE -> clr_ready = 0 that cycle; clear accepted the following cycle. Assert rst_n low during SERVE -> no pop_valid, all outputs 0.
